dcache_mshr: RTL and testbench

Non-blocking miss-status holding register file for the data cache. Accepts block-fill misses and dirty-block writebacks from up to `NUM_CH` cache ports per cycle, holds them in `NUM_ENTRIES` entries, issues at most one memory command per cycle, and matches returning memory tags to deliver completed fills back to the cache array. Sits between the dcache tag/data arrays and the shared memory port; it raises `dcache_request` so the icache yields the port.

---
 rtl/dcache_mshr_pkg.sv | 38 +++
 rtl/dcache_mshr_if.sv | 44 ++++
 rtl/dcache_mshr_rr_arbiter.sv | 32 +++
 rtl/dcache_mshr.sv | 163 ++++++++++++++++
 tb/tb_dcache_mshr.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_mshr_pkg.sv
// Shared types and constants for the data-cache MSHR slice.
//   DCACHE_MSHR_ENTRIES : default MSHR depth
//   DMSHR_STATE         : entry state encoding (INVALID/LD_PEND/LD_WAIT/WB_PEND)
//   DMSHR_ENTRY         : state, block address, memory tag, writeback data
//   MEM_COMMAND         : memory command encoding (MEM_NONE/MEM_LOAD/MEM_STORE)
package dcache_mshr_pkg;

    localparam int unsigned N                   = 2;
    localparam int unsigned DCACHE_MSHR_ENTRIES = 4;

    typedef logic [31:0] ADDR;
    typedef logic [3:0]  MEM_TAG;
    typedef logic [63:0] MEM_BLOCK;

    typedef logic [1:0] MEM_COMMAND;
    localparam MEM_COMMAND MEM_NONE  = 2'h0;
    localparam MEM_COMMAND MEM_LOAD  = 2'h1;
    localparam MEM_COMMAND MEM_STORE = 2'h2;

    typedef logic [1:0] DMSHR_STATE;
    localparam DMSHR_STATE INVALID = 2'h0;
    localparam DMSHR_STATE LD_PEND = 2'h1;
    localparam DMSHR_STATE LD_WAIT = 2'h2;
    localparam DMSHR_STATE WB_PEND = 2'h3;

    typedef struct packed {
        DMSHR_STATE state;
        ADDR        addr;
        MEM_TAG     tag;
        MEM_BLOCK   data;
    } DMSHR_ENTRY;

    // Block number: the address with the byte-in-block bits dropped.
    function automatic logic [28:0] block_num(input ADDR a);
        return a[31:3];
    endfunction

endpackage

// File: rtl/dcache_mshr_if.sv
// Bundle of the MSHR's cache-side request channels and memory-side port.
//   slave  : the MSHR (takes requests and memory responses, drives commands/fills)
//   master : the cache/memory environment
interface dcache_mshr_if import dcache_mshr_pkg::*; #(
    parameter int unsigned NUM_CH = N
) ();

    // Cache request channels
    logic [NUM_CH-1:0] req_valid;
    ADDR               req_addr    [NUM_CH];
    logic [NUM_CH-1:0] req_wb;
    MEM_BLOCK          req_wb_data [NUM_CH];
    logic [NUM_CH-1:0] req_accept;

    // Memory port
    MEM_TAG     Dmem2proc_transaction_tag;
    MEM_BLOCK   Dmem2proc_data;
    MEM_TAG     Dmem2proc_data_tag;
    MEM_COMMAND proc2Dmem_command;
    ADDR        proc2Dmem_addr;
    MEM_BLOCK   proc2Dmem_data;
    logic       dcache_request;

    // Fill return and status
    logic     fill_valid;
    ADDR      fill_addr;
    MEM_BLOCK fill_data;
    logic     mshr_empty;

    modport slave (
        input  req_valid, req_addr, req_wb, req_wb_data,
        input  Dmem2proc_transaction_tag, Dmem2proc_data, Dmem2proc_data_tag,
        output req_accept, proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        output dcache_request, fill_valid, fill_addr, fill_data, mshr_empty
    );

    modport master (
        output req_valid, req_addr, req_wb, req_wb_data,
        output Dmem2proc_transaction_tag, Dmem2proc_data, Dmem2proc_data_tag,
        input  req_accept, proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        input  dcache_request, fill_valid, fill_addr, fill_data, mshr_empty
    );

endinterface

// File: rtl/dcache_mshr_rr_arbiter.sv
// Round-robin pick: grants the first set bit of req_i at or after ptr_i (wrapping).
//   req_i   : request vector
//   ptr_i   : starting index
//   grant_o : one-hot grant
//   valid_o : any request granted
module rr_arbiter #(
    parameter int unsigned Width = 4,
    localparam int unsigned PtrW = $clog2(Width)
) (
    input  logic [Width-1:0] req_i,
    input  logic [PtrW-1:0]  ptr_i,
    output logic [Width-1:0] grant_o,
    output logic             valid_o
);

    logic [PtrW-1:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            // Width is a power of two, so the add wraps naturally.
            idx = ptr_i + PtrW'(i);
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_mshr.sv
// Non-blocking MSHR file for the data cache. Accepts fill misses and dirty writebacks on
// NUM_CH channels per cycle, issues at most one memory command per cycle (round-robin),
// and matches returning data tags to deliver fills.
//   clock, reset : clock and synchronous active-high reset
//   bus          : dcache_mshr_if.slave (requests, memory port, fill return, mshr_empty)
// Build option: DCACHE_MSHR_MERGE_EN merges secondary fill misses into an outstanding load;
// without it such misses are rejected.
module dcache_mshr import dcache_mshr_pkg::*; #(
    parameter int unsigned NUM_ENTRIES = DCACHE_MSHR_ENTRIES,
    parameter int unsigned NUM_CH      = N
) (
    input logic          clock,
    input logic          reset,
    dcache_mshr_if.slave bus
);

    localparam int unsigned PtrW = $clog2(NUM_ENTRIES);

    DMSHR_ENTRY             entries_q [NUM_ENTRIES];
    DMSHR_ENTRY             entries_d [NUM_ENTRIES];
    logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_ENTRIES-1:0] pend_vec, grant, claimed;
    logic                   issue_valid, issue_taken, fill_hit, ld_hit, wb_hit, need_alloc;
    logic [PtrW-1:0]        issue_idx, fill_idx;
    logic [NUM_CH-1:0]      accept, acc_fill, acc_wb;
    logic [28:0]            blk;

    always_comb begin
        for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
            pend_vec[e] = (entries_q[e].state == LD_PEND) || (entries_q[e].state == WB_PEND);
        end
    end

    rr_arbiter #(.Width(NUM_ENTRIES)) u_arb (
        .req_i   (pend_vec),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .valid_o (issue_valid)
    );

    // Issue and fill decode, plus memory-side and fill outputs.
    always_comb begin
        issue_idx = '0;
        fill_hit  = 1'b0;
        fill_idx  = '0;
        for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
            if (grant[e]) issue_idx = PtrW'(e);
            if (!fill_hit && entries_q[e].state == LD_WAIT && bus.Dmem2proc_data_tag != '0 &&
                entries_q[e].tag == bus.Dmem2proc_data_tag) begin
                fill_hit = 1'b1;
                fill_idx = PtrW'(e);
            end
        end

        bus.proc2Dmem_command = MEM_NONE;
        if (!reset && issue_valid) begin
            bus.proc2Dmem_command = (entries_q[issue_idx].state == LD_PEND) ? MEM_LOAD
                                                                            : MEM_STORE;
        end
        bus.dcache_request = (bus.proc2Dmem_command != MEM_NONE);
        bus.proc2Dmem_addr = bus.dcache_request ? entries_q[issue_idx].addr : '0;
        bus.proc2Dmem_data = (bus.proc2Dmem_command == MEM_STORE) ? entries_q[issue_idx].data
                                                                  : '0;
        issue_taken        = bus.dcache_request && (bus.Dmem2proc_transaction_tag != '0);

        bus.fill_valid = !reset && fill_hit;
        bus.fill_addr  = bus.fill_valid ? entries_q[fill_idx].addr : '0;
        bus.fill_data  = bus.fill_valid ? bus.Dmem2proc_data : '0;

        bus.mshr_empty = 1'b1;
        for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
            if (entries_q[e].state != INVALID) bus.mshr_empty = 1'b0;
        end
        if (reset) bus.mshr_empty = 1'b1;
    end

    // Next state: issue, fill, then allocation into entries that were INVALID at cycle start.
    always_comb begin
        entries_d  = entries_q;
        rr_ptr_d   = rr_ptr_q;
        claimed    = '0;
        accept     = '0;
        acc_fill   = '0;
        acc_wb     = '0;
        blk        = '0;
        ld_hit     = 1'b0;
        wb_hit     = 1'b0;
        need_alloc = 1'b0;

        if (issue_taken) begin
            if (entries_q[issue_idx].state == LD_PEND) begin
                entries_d[issue_idx].state = LD_WAIT;
                entries_d[issue_idx].tag   = bus.Dmem2proc_transaction_tag;
            end else begin
                entries_d[issue_idx].state = INVALID;
            end
            rr_ptr_d = issue_idx + PtrW'(1);
        end
        if (fill_hit) entries_d[fill_idx].state = INVALID;

        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            blk    = block_num(bus.req_addr[ch]);
            ld_hit = 1'b0;
            wb_hit = 1'b0;
            for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
                if (block_num(entries_q[e].addr) == blk) begin
                    if (entries_q[e].state == WB_PEND) wb_hit = 1'b1;
                    // A load being filled this cycle is gone; don't merge into it.
                    if (entries_q[e].state == LD_PEND ||
                        (entries_q[e].state == LD_WAIT && !(fill_hit && fill_idx == PtrW'(e))))
                        ld_hit = 1'b1;
                end
            end
            for (int unsigned j = 0; j < NUM_CH; j++) begin
                if (j < ch && block_num(bus.req_addr[j]) == blk) begin
                    if (acc_wb[j])   wb_hit = 1'b1;
                    if (acc_fill[j]) ld_hit = 1'b1;
                end
            end

            need_alloc = 1'b0;
            if (bus.req_valid[ch] && !reset) begin
                if (bus.req_wb[ch]) begin
                    need_alloc = 1'b1;
                end else if (!wb_hit) begin
`ifdef DCACHE_MSHR_MERGE_EN
                    if (ld_hit) accept[ch] = 1'b1;
                    else        need_alloc = 1'b1;
`else
                    need_alloc = !ld_hit;
`endif
                end
            end

            if (need_alloc) begin
                for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
                    if (!accept[ch] && !claimed[e] && entries_q[e].state == INVALID) begin
                        claimed[e]         = 1'b1;
                        accept[ch]         = 1'b1;
                        entries_d[e].state = bus.req_wb[ch] ? WB_PEND : LD_PEND;
                        entries_d[e].addr  = {blk, 3'b000};
                        entries_d[e].tag   = '0;
                        entries_d[e].data  = bus.req_wb[ch] ? bus.req_wb_data[ch] : '0;
                    end
                end
            end
            acc_wb[ch]   = accept[ch] && bus.req_wb[ch];
            acc_fill[ch] = accept[ch] && !bus.req_wb[ch];
        end
        bus.req_accept = accept;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned e = 0; e < NUM_ENTRIES; e++) entries_q[e] <= '0;
            rr_ptr_q <= '0;
        end else begin
            entries_q <= entries_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_dcache_mshr.sv
// Directed self-checking bench for dcache_mshr (4 entries, 2 channels).
module tb_dcache_mshr;
    import dcache_mshr_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    localparam logic [63:0] FILL_D = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] WB_D   = 64'hCAFE_F00D_1234_5678;
`ifdef DCACHE_MSHR_MERGE_EN
    localparam logic [1:0]  MERGE_ACC = 2'b11;
`else
    localparam logic [1:0]  MERGE_ACC = 2'b01;
`endif

    dcache_mshr_if #(.NUM_CH(2)) bus ();

    dcache_mshr #(.NUM_ENTRIES(4), .NUM_CH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        bus.req_valid                 = '0;
        bus.req_wb                    = '0;
        bus.req_addr[0]               = '0;
        bus.req_addr[1]               = '0;
        bus.req_wb_data[0]            = '0;
        bus.req_wb_data[1]            = '0;
        bus.Dmem2proc_transaction_tag = '0;
        bus.Dmem2proc_data            = '0;
        bus.Dmem2proc_data_tag        = '0;
    endtask

    task automatic set_req(input int ch, input logic [31:0] a, input logic wb,
                           input logic [63:0] d);
        bus.req_valid[ch]   = 1'b1;
        bus.req_addr[ch]    = a;
        bus.req_wb[ch]      = wb;
        bus.req_wb_data[ch] = d;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        set_req(0, 32'h1000, 1'b0, '0);
        set_req(1, 32'h2000, 1'b1, WB_D);
        bus.Dmem2proc_data_tag = 4'd1;
        cycle();
        cycle();
        checks++; if (bus.proc2Dmem_command !== MEM_NONE) begin errors++;
            $display("FAIL rst_cmd got %h exp %h", bus.proc2Dmem_command, MEM_NONE); end
        checks++; if (bus.proc2Dmem_addr !== 32'h0) begin errors++;
            $display("FAIL rst_addr got %h exp 0", bus.proc2Dmem_addr); end
        checks++; if (bus.proc2Dmem_data !== 64'h0) begin errors++;
            $display("FAIL rst_data got %h exp 0", bus.proc2Dmem_data); end
        checks++; if (bus.dcache_request !== 1'b0) begin errors++;
            $display("FAIL rst_dreq got %b exp 0", bus.dcache_request); end
        checks++; if (bus.fill_valid !== 1'b0 || bus.fill_addr !== 32'h0) begin errors++;
            $display("FAIL rst_fill got %b/%h exp 0/0", bus.fill_valid, bus.fill_addr); end
        checks++; if (bus.fill_data !== 64'h0) begin errors++;
            $display("FAIL rst_fill_data got %h exp 0", bus.fill_data); end
        checks++; if (bus.req_accept !== 2'b00) begin errors++;
            $display("FAIL rst_accept got %b exp 00", bus.req_accept); end
        checks++; if (bus.mshr_empty !== 1'b1) begin errors++;
            $display("FAIL rst_empty got %b exp 1", bus.mshr_empty); end
        reset = 1'b0;
        idle();
        cycle();
    endtask

    task automatic test_single();
        idle();
        set_req(0, 32'h1005, 1'b0, '0);
        #1;
        checks++; if (bus.req_accept !== 2'b01) begin errors++;
            $display("FAIL single_accept got %b exp 01", bus.req_accept); end
        checks++; if (bus.dcache_request !== 1'b0) begin errors++;
            $display("FAIL single_early_cmd got %b exp 0", bus.dcache_request); end
        cycle();
        idle();
        bus.Dmem2proc_transaction_tag = 4'd3;
        #1;
        checks++; if (bus.proc2Dmem_command !== MEM_LOAD || bus.proc2Dmem_addr !== 32'h1000)
            begin errors++; $display("FAIL single_load got %h/%h exp %h/00001000",
                                     bus.proc2Dmem_command, bus.proc2Dmem_addr, MEM_LOAD); end
        checks++; if (bus.proc2Dmem_data !== 64'h0 || bus.mshr_empty !== 1'b0) begin errors++;
            $display("FAIL single_ld_data got %h/%b exp 0/0", bus.proc2Dmem_data,
                     bus.mshr_empty); end
        cycle();
        idle();
        #1;
        checks++; if (bus.proc2Dmem_command !== MEM_NONE) begin errors++;
            $display("FAIL single_wait_cmd got %h exp %h", bus.proc2Dmem_command, MEM_NONE); end
        bus.Dmem2proc_data_tag = 4'd3;
        bus.Dmem2proc_data     = FILL_D;
        #1;
        checks++; if (bus.fill_valid !== 1'b1 || bus.fill_addr !== 32'h1000) begin errors++;
            $display("FAIL single_fill got %b/%h exp 1/00001000", bus.fill_valid,
                     bus.fill_addr); end
        checks++; if (bus.fill_data !== FILL_D) begin errors++;
            $display("FAIL single_fill_data got %h exp %h", bus.fill_data, FILL_D); end
        cycle();
        idle();
        #1;
        checks++; if (bus.mshr_empty !== 1'b1 || bus.fill_valid !== 1'b0) begin errors++;
            $display("FAIL single_empty got %b/%b exp 1/0", bus.mshr_empty, bus.fill_valid); end
    endtask

    task automatic test_merge();
        idle();
        set_req(0, 32'h2000, 1'b0, '0);
        set_req(1, 32'h2004, 1'b0, '0);
        #1;
        checks++; if (bus.req_accept !== MERGE_ACC) begin errors++;
            $display("FAIL merge_accept got %b exp %b", bus.req_accept, MERGE_ACC); end
        cycle();
        idle();
        bus.Dmem2proc_transaction_tag = 4'd5;
        #1;
        checks++; if (bus.proc2Dmem_command !== MEM_LOAD || bus.proc2Dmem_addr !== 32'h2000)
            begin errors++; $display("FAIL merge_load got %h/%h exp 1/00002000",
                                     bus.proc2Dmem_command, bus.proc2Dmem_addr); end
        cycle();
        idle();
        #1;
        checks++; if (bus.proc2Dmem_command !== MEM_NONE) begin errors++;
            $display("FAIL merge_one_load got %h exp 0", bus.proc2Dmem_command); end
        bus.Dmem2proc_data_tag = 4'd5;
        #1;
        checks++; if (bus.fill_valid !== 1'b1 || bus.fill_addr !== 32'h2000) begin errors++;
            $display("FAIL merge_fill got %b/%h exp 1/00002000", bus.fill_valid,
                     bus.fill_addr); end
        cycle();
        idle();
        #1;
        checks++; if (bus.mshr_empty !== 1'b1) begin errors++;
            $display("FAIL merge_empty got %b exp 1", bus.mshr_empty); end
    endtask

    task automatic test_tag_zero();
        idle();
        set_req(0, 32'h5000, 1'b0, '0);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.proc2Dmem_command !== MEM_LOAD || bus.proc2Dmem_addr !== 32'h5000)
                begin errors++; $display("FAIL tag0_retry%0d got %h/%h exp 1/00005000", i,
                                         bus.proc2Dmem_command, bus.proc2Dmem_addr); end
            cycle();
        end
        bus.Dmem2proc_transaction_tag = 4'd7;
        cycle();
        idle();
        bus.Dmem2proc_data_tag = 4'd9;
        #1;
        checks++; if (bus.proc2Dmem_command !== MEM_NONE || bus.fill_valid !== 1'b0) begin
            errors++; $display("FAIL tag0_wait got %h/%b exp 0/0", bus.proc2Dmem_command,
                               bus.fill_valid); end
        cycle();
        bus.Dmem2proc_data_tag = 4'd7;
        #1;
        checks++; if (bus.fill_valid !== 1'b1 || bus.fill_addr !== 32'h5000) begin errors++;
            $display("FAIL tag0_fill got %b/%h exp 1/00005000", bus.fill_valid,
                     bus.fill_addr); end
        cycle();
        idle();
    endtask

    task automatic test_wb_conflict();
        idle();
        set_req(0, 32'h3000, 1'b1, WB_D);
        set_req(1, 32'h3000, 1'b0, '0);
        #1;
        checks++; if (bus.req_accept !== 2'b01) begin errors++;
            $display("FAIL wb_same_cycle got %b exp 01", bus.req_accept); end
        cycle();
        idle();
        set_req(0, 32'h3000, 1'b0, '0);
        #1;
        checks++; if (bus.req_accept !== 2'b00) begin errors++;
            $display("FAIL wb_pend_reject got %b exp 00", bus.req_accept); end
        checks++; if (bus.proc2Dmem_command !== MEM_STORE || bus.proc2Dmem_data !== WB_D ||
                      bus.proc2Dmem_addr !== 32'h3000) begin errors++;
            $display("FAIL wb_store got %h/%h/%h exp 2/00003000/%h", bus.proc2Dmem_command,
                     bus.proc2Dmem_addr, bus.proc2Dmem_data, WB_D); end
        cycle();
        bus.Dmem2proc_transaction_tag = 4'd2;
        #1;
        checks++; if (bus.req_accept !== 2'b00) begin errors++;
            $display("FAIL wb_taken_reject got %b exp 00", bus.req_accept); end
        cycle();
        bus.Dmem2proc_transaction_tag = 4'd0;
        #1;
        checks++; if (bus.req_accept !== 2'b01 || bus.proc2Dmem_command !== MEM_NONE) begin
            errors++; $display("FAIL wb_retry got %b/%h exp 01/0", bus.req_accept,
                               bus.proc2Dmem_command); end
        cycle();
        idle();
        bus.Dmem2proc_transaction_tag = 4'd8;
        #1;
        checks++; if (bus.proc2Dmem_command !== MEM_LOAD || bus.proc2Dmem_data !== 64'h0) begin
            errors++; $display("FAIL wb_then_load got %h/%h exp 1/0", bus.proc2Dmem_command,
                               bus.proc2Dmem_data); end
        cycle();
        idle();
        bus.Dmem2proc_data_tag = 4'd8;
        cycle();
        idle();
    endtask

    // Leaves rr_ptr at 1 from earlier tests; ends with a mid-flight reset.
    task automatic test_full();
        idle();
        set_req(0, 32'h4000, 1'b0, '0);
        set_req(1, 32'h4040, 1'b0, '0);
        cycle();
        set_req(0, 32'h4080, 1'b0, '0);
        set_req(1, 32'h40C0, 1'b0, '0);
        #1;
        checks++; if (bus.req_accept !== 2'b11 || bus.proc2Dmem_addr !== 32'h4040) begin
            errors++; $display("FAIL full_fill4 got %b/%h exp 11/00004040", bus.req_accept,
                               bus.proc2Dmem_addr); end
        cycle();
        idle();
        set_req(0, 32'h4100, 1'b0, '0);
        bus.Dmem2proc_transaction_tag = 4'd1;
        #1;
        checks++; if (bus.req_accept !== 2'b00 || bus.proc2Dmem_addr !== 32'h4040) begin
            errors++; $display("FAIL full_reject got %b/%h exp 00/00004040", bus.req_accept,
                               bus.proc2Dmem_addr); end
        cycle();
        bus.Dmem2proc_transaction_tag = 4'd2;
        #1;
        checks++; if (bus.proc2Dmem_addr !== 32'h4080) begin errors++;
            $display("FAIL full_rr2 got %h exp 00004080", bus.proc2Dmem_addr); end
        cycle();
        bus.Dmem2proc_transaction_tag = 4'd3;
        #1;
        checks++; if (bus.proc2Dmem_addr !== 32'h40C0) begin errors++;
            $display("FAIL full_rr3 got %h exp 000040c0", bus.proc2Dmem_addr); end
        cycle();
        bus.Dmem2proc_transaction_tag = 4'd4;
        #1;
        checks++; if (bus.proc2Dmem_addr !== 32'h4000) begin errors++;
            $display("FAIL full_rr_wrap got %h exp 00004000", bus.proc2Dmem_addr); end
        cycle();
        bus.Dmem2proc_transaction_tag = 4'd0;
        bus.Dmem2proc_data_tag        = 4'd3;
        #1;
        checks++; if (bus.fill_addr !== 32'h40C0 || bus.req_accept !== 2'b00) begin errors++;
            $display("FAIL full_free_same got %h/%b exp 000040c0/00", bus.fill_addr,
                     bus.req_accept); end
        cycle();
        bus.Dmem2proc_data_tag = 4'd0;
        #1;
        checks++; if (bus.req_accept !== 2'b01) begin errors++;
            $display("FAIL full_free_next got %b exp 01", bus.req_accept); end
        cycle();
        idle();
        #1;
        checks++; if (bus.proc2Dmem_addr !== 32'h4100) begin errors++;
            $display("FAIL full_new_load got %h exp 00004100", bus.proc2Dmem_addr); end
        reset = 1'b1;
        set_req(0, 32'h7000, 1'b0, '0);
        bus.Dmem2proc_data_tag        = 4'd1;
        bus.Dmem2proc_transaction_tag = 4'd6;
        #1;
        checks++; if (bus.proc2Dmem_command !== MEM_NONE || bus.fill_valid !== 1'b0 ||
                      bus.req_accept !== 2'b00 || bus.proc2Dmem_addr !== 32'h0) begin errors++;
            $display("FAIL midrst_out got %h/%b/%b/%h exp 0/0/00/0", bus.proc2Dmem_command,
                     bus.fill_valid, bus.req_accept, bus.proc2Dmem_addr); end
        cycle();
        reset = 1'b0;
        idle();
        bus.Dmem2proc_data_tag = 4'd1;
        #1;
        checks++; if (bus.mshr_empty !== 1'b1 || bus.fill_valid !== 1'b0 ||
                      bus.dcache_request !== 1'b0) begin errors++;
            $display("FAIL midrst_cleared got %b/%b/%b exp 1/0/0", bus.mshr_empty,
                     bus.fill_valid, bus.dcache_request); end
        idle();
        cycle();
    endtask

    // rr_ptr is 0 after the reset in test_full.
    task automatic test_round_robin();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h6000;
        exp_addr[1] = 32'h6040;
        exp_addr[2] = 32'h6080;
        exp_addr[3] = 32'h60C0;
        idle();
        set_req(0, 32'h6000, 1'b0, '0);
        set_req(1, 32'h6040, 1'b0, '0);
        cycle();
        set_req(0, 32'h6080, 1'b0, '0);
        set_req(1, 32'h60C0, 1'b0, '0);
        cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.Dmem2proc_transaction_tag = 4'(i + 1);
            bus.Dmem2proc_data_tag        = (i == 1) ? 4'd1 : 4'd0;
            #1;
            checks++; if (bus.proc2Dmem_addr !== exp_addr[i]) begin errors++;
                $display("FAIL rr_order%0d got %h exp %h", i, bus.proc2Dmem_addr,
                         exp_addr[i]); end
            if (i == 1) begin
                checks++; if (bus.fill_valid !== 1'b1 || bus.fill_addr !== 32'h6000) begin
                    errors++; $display("FAIL rr_issue_fill got %b/%h exp 1/00006000",
                                       bus.fill_valid, bus.fill_addr); end
            end
            cycle();
        end
        idle();
        bus.Dmem2proc_data_tag = 4'd4;
        #1;
        checks++; if (bus.fill_addr !== 32'h60C0) begin errors++;
            $display("FAIL rr_ooo_tag4 got %h exp 000060c0", bus.fill_addr); end
        cycle();
        bus.Dmem2proc_data_tag = 4'd2;
        #1;
        checks++; if (bus.fill_addr !== 32'h6040) begin errors++;
            $display("FAIL rr_ooo_tag2 got %h exp 00006040", bus.fill_addr); end
        cycle();
        bus.Dmem2proc_data_tag = 4'd3;
        #1;
        checks++; if (bus.fill_addr !== 32'h6080) begin errors++;
            $display("FAIL rr_ooo_tag3 got %h exp 00006080", bus.fill_addr); end
        cycle();
        idle();
        #1;
        checks++; if (bus.mshr_empty !== 1'b1) begin errors++;
            $display("FAIL rr_empty got %b exp 1", bus.mshr_empty); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_merge();
        test_tag_zero();
        test_wb_conflict();
        test_full();
        test_round_robin();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
